// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch stage plus IF/ID pipeline register.
//
// Holds the PC and keeps at most one request open to instruction memory
// (imem_req/imem_addr level, imem_ready completes it). The fetched word and
// its PC+4 are registered into IF/ID for decode; opcode taps the top six
// bits of the registered instruction for the control unit.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   imem_req, imem_addr     fetch request / word-aligned address (= PC)
//   imem_rdata, imem_ready  returned instruction word / completion strobe
//   stall                   hazard unit holds PC and IF/ID
//   branch_taken/_target    absolute branch redirect
//   jump, jump_index        J-type redirect using if_id_pc4[31:28]
//   if_id_instr/_pc4/_valid IF/ID register contents
//   opcode                  if_id_instr[31:26]
//
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched (accepted fetches)
// and perf_flush (redirect cycles) counters.

module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [15:0] perf_flush
`endif
);

  typedef enum logic {REQ, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = branch_taken | jump;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (redirect) begin
      // Branch outranks jump; any returning data and the hold buffer are dropped.
      if (branch_taken) pc_d = branch_target & ~32'h3;
      else              pc_d = {pc4_q[31:28], jump_index, 2'b00};
      state_d = REQ;
      hold_d  = '0;
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (state_q == HOLD) begin
      // While holding, PC already points past the buffered word, so PC is its PC+4.
      if (!stall) begin
        instr_d = hold_q;
        pc4_d   = pc_q;
        valid_d = 1'b1;
        state_d = REQ;
      end
    end else if (imem_ready) begin
      pc_d = pc_plus4;
      if (stall) begin
        hold_d  = imem_rdata;
        state_d = HOLD;
      end else begin
        instr_d = imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end else if (!stall) begin
      // Waiting on memory with decode free: push an all-zero bubble.
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= PC_RESET & ~32'h3;
      hold_q  <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign opcode      = instr_q[31:26];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [15:0] flush_q;
  logic        fetch_acc;

  // A word counts whether it goes to IF/ID or the hold buffer, unless a redirect drops it.
  assign fetch_acc = (state_q == REQ) & imem_ready & ~redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flush_q   <= '0;
    end else begin
      if (fetch_acc) fetched_q <= fetched_q + 32'd1;
      if (redirect)  flush_q   <= flush_q + 16'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flush   = flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_flush;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .opcode(opcode)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_flush(perf_flush)
`endif
  );

  // Instruction memory contents: a fixed word at 0, a scrambled address elsewhere.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C22_0004;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  assign imem_rdata = word(imem_addr);

  int checks = 0;
  int failures = 0;

  // Reference model: architectural fetch state.
  logic [31:0] m_pc;
  logic        m_holding;
  logic [31:0] m_hold;
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_pc = 32'h0; m_holding = 1'b0; m_hold = '0;
      m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (branch_taken || jump) begin
      m_pc = branch_taken ? {branch_target[31:2], 2'b00}
                          : {m_pc4[31:28], jump_index, 2'b00};
      m_holding = 1'b0; m_hold = '0;
      m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (m_holding) begin
      if (!stall) begin
        m_instr = m_hold; m_pc4 = m_pc; m_valid = 1'b1; m_holding = 1'b0;
      end
    end else if (imem_ready) begin
      if (stall) begin
        m_hold = word(m_pc); m_holding = 1'b1;
      end else begin
        m_instr = word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("imem_req",    {31'b0, imem_req},    {31'b0, !m_holding});
    chk("imem_addr",   imem_addr,            m_pc);
    chk("if_id_instr", if_id_instr,          m_instr);
    chk("if_id_pc4",   if_id_pc4,            m_pc4);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("opcode",      {26'b0, opcode},      {26'b0, m_instr[31:26]});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic redirect_to(input logic [31:0] t);
    branch_taken = 1'b1; branch_target = t;
    cyc();
    branch_taken = 1'b0;
  endtask

  logic [31:0] a0, ii;

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_index = '0;
    m_pc = '0; m_holding = 1'b0; m_hold = '0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_req",   {31'b0, imem_req}, 32'd1);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);

    // First zero-wait fetch
    rst_n = 1'b1;
    chk("first_addr", imem_addr, 32'h0);
    cyc();
    chk("first_instr",  if_id_instr, 32'h8C22_0004);
    chk("first_pc4",    if_id_pc4, 32'd4);
    chk("first_opcode", {26'b0, opcode}, 32'h23);
    cyc(); cyc();

    // Two wait states per fetch
    for (int k = 0; k < 3; k++) begin
      a0 = imem_addr;
      imem_ready = 1'b0;
      cyc(); cyc();
      chk("wait_addr_held", imem_addr, a0);
      chk("wait_bubble", {31'b0, if_id_valid}, 32'd0);
      imem_ready = 1'b1;
      cyc();
      chk("wait_addr_adv", imem_addr, a0 + 32'd4);
    end

    // Stall while ready at address 8
    redirect_to(32'h4);
    cyc();
    ii = word(32'h4);
    stall = 1'b1;
    cyc();
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    cyc(); cyc();
    chk("stall_keep", if_id_instr, ii);
    stall = 1'b0;
    cyc();
    chk("release_instr", if_id_instr, word(32'h8));
    chk("release_pc4",   if_id_pc4, 32'd12);
    chk("release_addr",  imem_addr, 32'd12);

    // Branch while in HOLD
    stall = 1'b1;
    cyc();
    chk("hold2_req", {31'b0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h40;
    cyc();
    branch_taken = 1'b0; stall = 1'b0;
    chk("br_hold_valid",  {31'b0, if_id_valid}, 32'd0);
    chk("br_hold_opcode", {26'b0, opcode}, 32'd0);
    chk("br_hold_addr",   imem_addr, 32'h40);
    chk("br_hold_req",    {31'b0, imem_req}, 32'd1);

    // Misaligned target truncation, PC wrap
    redirect_to(32'h43);
    chk("align_addr", imem_addr, 32'h40);
    redirect_to(32'hFFFF_FFFC);
    cyc();
    chk("wrap_pc4",   if_id_pc4, 32'h0);
    chk("wrap_addr",  imem_addr, 32'h0);
    chk("wrap_valid", {31'b0, if_id_valid}, 32'd1);

    // Stall while memory waits keeps IF/ID
    imem_ready = 1'b0; stall = 1'b1;
    cyc(); cyc();
    imem_ready = 1'b1; stall = 1'b0;
    cyc();

    // Branch beats jump
    redirect_to(32'h1000_0004);
    cyc();
    chk("j_setup_pc4", if_id_pc4, 32'h1000_0008);
    jump = 1'b1; jump_index = 26'h000_0010;
    branch_taken = 1'b1; branch_target = 32'h80;
    cyc();
    jump = 1'b0; branch_taken = 1'b0;
    chk("br_wins_addr", imem_addr, 32'h80);

    // Jump alone
    redirect_to(32'h1000_0004);
    cyc();
    jump = 1'b1;
    cyc();
    jump = 1'b0;
    chk("jump_addr", imem_addr, 32'h1000_0040);
    cyc(); cyc();

    // Reset during a wait-state request at 0x20
    redirect_to(32'h20);
    imem_ready = 1'b0;
    cyc();
    chk("pre_rst_addr", imem_addr, 32'h20);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_addr",  imem_addr, 32'h0);
    chk("mid_rst_instr", if_id_instr, 32'h0);
    chk("mid_rst_pc4",   if_id_pc4, 32'h0);
    chk("mid_rst_valid", {31'b0, if_id_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_rst", perf_fetched, 32'h0);
    chk("perf_flush_rst",   {16'b0, perf_flush}, 32'h0);
`endif
    rst_n = 1'b1; imem_ready = 1'b1;
    cyc(); cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
